sdram_port_arbiter: RTL

//  Shares the single SDRAM controller command port among three requesters in the clk_sys (100MHz) domain:
//  the VGA line-fill port (burst read), the CPU port (single word) and the DMA/blitter port (burst).

---
 rtl/sdram_port_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the SDRAM controller command port between the
// VGA line-fill port (strict priority), the CPU port and the DMA port
// (round-robin between CPU and DMA). Data paths are combinational and
// gated by the current owner.
module sdram_port_arbiter #(
    parameter int LINE_LEN    = 1024,
    parameter int DMA_MAX_LEN = 256
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        line_req,
    input  logic [23:0] line_addr,
    output logic        line_grant,
    output logic [15:0] line_data,
    output logic        line_valid,
    output logic        line_done,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [23:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [23:0] dma_addr,
    input  logic [10:0] dma_len,
    input  logic [15:0] dma_wdata,
    output logic        dma_grant,
    output logic        dma_wnext,
    output logic [15:0] dma_rdata,
    output logic        dma_rvalid,
    output logic        dma_done,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    output logic [10:0] mem_len,
    output logic [15:0] mem_wdata,
    input  logic        mem_wnext,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid,
    input  logic        mem_done,
    output logic [1:0]  dbg_owner
);

    // S_ZLEN is the single-cycle grant/done pulse of a zero-length DMA request
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_XFER, S_RELEASE, S_ZLEN
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_LINE = 2'd1;
    localparam logic [1:0] OWN_CPU  = 2'd2;
    localparam logic [1:0] OWN_DMA  = 2'd3;

    state_t      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic        rr_last_q, rr_last_d;     // 1: DMA was served last, 0: CPU
    logic [23:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [10:0] len_q, len_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [10:0] dma_len_clamped;
    logic        cpu_wins;
    logic        xfer_done;
    logic        busy;

    assign dma_len_clamped = (dma_len > 11'(DMA_MAX_LEN)) ? 11'(DMA_MAX_LEN) : dma_len;
    // CPU takes a CPU/DMA tie only when DMA went last
    assign cpu_wins  = cpu_req && (!dma_req || rr_last_q);
    // mem_done only counts once the command has been accepted
    assign xfer_done = (state_q == S_XFER) && mem_done;
    assign busy      = (state_q == S_ISSUE) || (state_q == S_XFER);

    // Next-state, arbitration and command latching
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        addr_d    = addr_q;
        we_d      = we_q;
        len_d     = len_q;
        unique case (state_q)
            S_IDLE: begin
                if (line_req) begin
                    state_d = S_ISSUE;
                    owner_d = OWN_LINE;
                    addr_d  = line_addr;
                    we_d    = 1'b0;
                    len_d   = 11'(LINE_LEN);
                end else if (cpu_wins) begin
                    state_d   = S_ISSUE;
                    owner_d   = OWN_CPU;
                    rr_last_d = 1'b0;
                    addr_d    = cpu_addr;
                    we_d      = cpu_we;
                    len_d     = 11'd1;
                end else if (dma_req) begin
                    owner_d   = OWN_DMA;
                    rr_last_d = 1'b1;
                    if (dma_len == 11'd0) begin
                        state_d = S_ZLEN;
                    end else begin
                        state_d = S_ISSUE;
                        addr_d  = dma_addr;
                        we_d    = dma_we;
                        len_d   = dma_len_clamped;
                    end
                end
            end
            S_ISSUE: if (mem_ack) state_d = S_XFER;
            S_XFER:  if (mem_done) state_d = S_RELEASE;
            S_RELEASE, S_ZLEN: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
                addr_d  = 24'd0;
                we_d    = 1'b0;
                len_d   = 11'd0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // CPU read data is captured on the beat and held until the next CPU read
    always_comb begin
        cpu_rdata_d = cpu_rdata_q;
        if (owner_q == OWN_CPU && !we_q && mem_rvalid) cpu_rdata_d = mem_rdata;
    end

    // State registers; rr_last starts at DMA so CPU wins the first tie
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            rr_last_q   <= 1'b1;
            addr_q      <= 24'd0;
            we_q        <= 1'b0;
            len_q       <= 11'd0;
            cpu_rdata_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_last_q   <= rr_last_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            len_q       <= len_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    // Owner-gated routing of grants, strobes and data
    always_comb begin
        mem_req    = (state_q == S_ISSUE);
        mem_we     = we_q;
        mem_addr   = addr_q;
        mem_len    = len_q;
        dbg_owner  = owner_q;
        cpu_rdata  = cpu_rdata_q;

        line_grant = (owner_q == OWN_LINE) && busy;
        line_valid = (owner_q == OWN_LINE) && mem_rvalid;
        line_data  = (owner_q == OWN_LINE) ? mem_rdata : 16'd0;
        line_done  = (owner_q == OWN_LINE) && xfer_done;

        cpu_ack    = (owner_q == OWN_CPU) && xfer_done;

        dma_grant  = (owner_q == OWN_DMA) && (busy || state_q == S_ZLEN);
        dma_rvalid = (owner_q == OWN_DMA) && mem_rvalid;
        dma_rdata  = (owner_q == OWN_DMA) ? mem_rdata : 16'd0;
        dma_wnext  = (owner_q == OWN_DMA) && mem_wnext;
        dma_done   = (owner_q == OWN_DMA) && (xfer_done || state_q == S_ZLEN);

        unique case (owner_q)
            OWN_CPU: mem_wdata = cpu_wdata;
            OWN_DMA: mem_wdata = dma_wdata;
            default: mem_wdata = 16'd0;
        endcase
    end

endmodule
